// File: rtl/sprite_fetch_if.sv
// -----------------------------------------------------------------------------
// sprite_fetch_if
// Bundles the sprite control registers, the beam position and the request
// interface towards the pixel arbiter.
//
// Handshake: request is a one-cycle strobe with no ready/back-pressure. The
// arbiter must consume address_out/layer_out in the cycle request is high.
// address_out holds its value until the next request.
//
// Signals
//   clk25en            pixel strobe, 1 cycle in 4
//   sprite_enable      show sprite
//   x_pos, y_pos       top-left screen position
//   width, height      source size in pixels (0 disables the sprite)
//   scale_x, scale_y   log2 scale factor per axis
//   flip_h, flip_v     mirror source columns / rows
//   address_in         base address in sprite RAM
//   layer_in           layer tag
//   curr_x_pos/_y_pos  current beam position
//   blank              1 = beam outside the visible area
//   layer_out          latched layer tag
//   address_out        address of the requested pixel
//   request            one-cycle request pulse
//   frame_done         one-cycle pulse with the last source pixel request
// Modports: master = control/beam side, slave = sprite_fetch.
// -----------------------------------------------------------------------------
interface sprite_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int POS_W   = 10,
  parameter int LAYER_W = 2
);
  logic               clk25en;
  logic               sprite_enable;
  logic [POS_W-1:0]   x_pos;
  logic [POS_W-1:0]   y_pos;
  logic [ADDR_W-1:0]  width;
  logic [ADDR_W-1:0]  height;
  logic [1:0]         scale_x;
  logic [1:0]         scale_y;
  logic               flip_h;
  logic               flip_v;
  logic [ADDR_W-1:0]  address_in;
  logic [LAYER_W-1:0] layer_in;
  logic [POS_W-1:0]   curr_x_pos;
  logic [POS_W-1:0]   curr_y_pos;
  logic               blank;
  logic [LAYER_W-1:0] layer_out;
  logic [ADDR_W-1:0]  address_out;
  logic               request;
  logic               frame_done;

  modport master (
    output clk25en, sprite_enable, x_pos, y_pos, width, height,
           scale_x, scale_y, flip_h, flip_v, address_in, layer_in,
           curr_x_pos, curr_y_pos, blank,
    input  layer_out, address_out, request, frame_done
  );

  modport slave (
    input  clk25en, sprite_enable, x_pos, y_pos, width, height,
           scale_x, scale_y, flip_h, flip_v, address_in, layer_in,
           curr_x_pos, curr_y_pos, blank,
    output layer_out, address_out, request, frame_done
  );
endinterface

// File: rtl/sprite_fetch.sv
// -----------------------------------------------------------------------------
// sprite_fetch
// Sprite pixel-request engine. For every pixel strobe whose beam position is
// covered by the (scaled, mirrored) sprite rectangle, issues one request to
// the pixel arbiter with address = base + row*width + col (mod 2^ADDR_W).
// Control inputs are shadowed at the (0,0) strobe so that mid-frame changes
// only take effect on the next frame.
//
// Ports
//   clk        system clock
//   resetn     asynchronous active-low reset
//   bus        sprite_fetch_if.slave (control, beam, request outputs)
//   state_dbg  current FSM state (0=IDLE, 1=ARMED, 2=DONE)
//
// Pipeline: strobe cycle T computes the hit test, T+1 holds hit/dx/dy,
// T+2 holds row/col, T+3 presents address_out together with request.
// -----------------------------------------------------------------------------
module sprite_fetch #(
  parameter int ADDR_W  = 8,
  parameter int POS_W   = 10,
  parameter int LAYER_W = 2
) (
  input  logic         clk,
  input  logic         resetn,
  sprite_fetch_if.slave bus,
  output logic [1:0]   state_dbg
);

  localparam int EXT_W = ADDR_W + 3;
  localparam int CW    = (POS_W > EXT_W) ? POS_W : EXT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Shadow registers
  // ---------------------------------------------------------------------------
  logic               latch;
  logic               arm_ok;
  logic [POS_W-1:0]   x_lat, y_lat;
  logic [ADDR_W-1:0]  w_lat, h_lat, base_lat;
  logic [1:0]         sx_lat, sy_lat;
  logic               fh_lat, fv_lat;
  logic [LAYER_W-1:0] layer_lat;

  always_comb begin
    latch  = bus.clk25en && (bus.curr_x_pos == '0) && (bus.curr_y_pos == '0);
    arm_ok = bus.sprite_enable && (bus.width != '0) && (bus.height != '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_lat     <= '0;
      y_lat     <= '0;
      w_lat     <= '0;
      h_lat     <= '0;
      base_lat  <= '0;
      sx_lat    <= '0;
      sy_lat    <= '0;
      fh_lat    <= 1'b0;
      fv_lat    <= 1'b0;
      layer_lat <= '0;
    end else if (latch) begin
      x_lat     <= bus.x_pos;
      y_lat     <= bus.y_pos;
      w_lat     <= bus.width;
      h_lat     <= bus.height;
      base_lat  <= bus.address_in;
      sx_lat    <= bus.scale_x;
      sy_lat    <= bus.scale_y;
      fh_lat    <= bus.flip_h;
      fv_lat    <= bus.flip_v;
      layer_lat <= bus.layer_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: hit test. On the latch strobe itself the incoming control values
  // are used, so a sprite placed at (0,0) does not lose its first pixel.
  // ---------------------------------------------------------------------------
  logic [POS_W-1:0]  e_x, e_y;
  logic [ADDR_W-1:0] e_w, e_h, e_base;
  logic [1:0]        e_sx, e_sy;
  logic              e_fh, e_fv;
  logic              armed_eff;
  logic [POS_W:0]    dx, dy;
  logic [EXT_W-1:0]  ext_x, ext_y;
  logic [CW-1:0]     dx_c, dy_c, ext_xc, ext_yc;
  logic              in_x, in_y;
  logic              hit0, last0;

  always_comb begin
    e_x       = latch ? bus.x_pos      : x_lat;
    e_y       = latch ? bus.y_pos      : y_lat;
    e_w       = latch ? bus.width      : w_lat;
    e_h       = latch ? bus.height     : h_lat;
    e_base    = latch ? bus.address_in : base_lat;
    e_sx      = latch ? bus.scale_x    : sx_lat;
    e_sy      = latch ? bus.scale_y    : sy_lat;
    e_fh      = latch ? bus.flip_h     : fh_lat;
    e_fv      = latch ? bus.flip_v     : fv_lat;
    armed_eff = latch ? arm_ok : (state_q == ARMED);

    // One extra bit so that a beam left of / above the sprite goes negative.
    dx     = {1'b0, bus.curr_x_pos} - {1'b0, e_x};
    dy     = {1'b0, bus.curr_y_pos} - {1'b0, e_y};
    ext_x  = {3'b000, e_w} << e_sx;
    ext_y  = {3'b000, e_h} << e_sy;
    dx_c   = CW'(dx[POS_W-1:0]);
    dy_c   = CW'(dy[POS_W-1:0]);
    ext_xc = CW'(ext_x);
    ext_yc = CW'(ext_y);
    in_x   = !dx[POS_W] && (dx_c < ext_xc);
    in_y   = !dy[POS_W] && (dy_c < ext_yc);
    hit0   = bus.clk25en && armed_eff && !bus.blank && in_x && in_y;
    // Last pixel is judged on unflipped screen coordinates.
    last0  = (dx_c == ext_xc - CW'(1)) && (dy_c == ext_yc - CW'(1));
  end

  // ---------------------------------------------------------------------------
  // Stage 1: hit, offsets and a snapshot of the parameters that go with them,
  // so an in-flight request is unaffected by a latch that lands behind it.
  // ---------------------------------------------------------------------------
  logic              s1_valid, s1_last;
  logic [POS_W-1:0]  s1_dx, s1_dy;
  logic [ADDR_W-1:0] s1_w, s1_h, s1_base;
  logic [1:0]        s1_sx, s1_sy;
  logic              s1_fh, s1_fv;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_w     <= '0;
      s1_h     <= '0;
      s1_base  <= '0;
      s1_sx    <= '0;
      s1_sy    <= '0;
      s1_fh    <= 1'b0;
      s1_fv    <= 1'b0;
    end else begin
      s1_valid <= hit0;
      s1_last  <= hit0 && last0;
      if (hit0) begin
        s1_dx   <= dx[POS_W-1:0];
        s1_dy   <= dy[POS_W-1:0];
        s1_w    <= e_w;
        s1_h    <= e_h;
        s1_base <= e_base;
        s1_sx   <= e_sx;
        s1_sy   <= e_sy;
        s1_fh   <= e_fh;
        s1_fv   <= e_fv;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: source column/row. dx < width<<scale, so dx>>scale < width and
  // fits in ADDR_W bits.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] col_raw, row_raw, col1, row1;

  always_comb begin
    col_raw = ADDR_W'(s1_dx >> s1_sx);
    row_raw = ADDR_W'(s1_dy >> s1_sy);
    col1    = s1_fh ? (s1_w - ADDR_W'(1) - col_raw) : col_raw;
    row1    = s1_fv ? (s1_h - ADDR_W'(1) - row_raw) : row_raw;
  end

  logic              s2_valid, s2_last;
  logic [ADDR_W-1:0] s2_col, s2_row, s2_w, s2_base;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_col   <= '0;
      s2_row   <= '0;
      s2_w     <= '0;
      s2_base  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) begin
        s2_col  <= col1;
        s2_row  <= row1;
        s2_w    <= s1_w;
        s2_base <= s1_base;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: address and request. The sum wraps mod 2^ADDR_W on purpose.
  // ---------------------------------------------------------------------------
  logic              request_q, frame_done_q;
  logic [ADDR_W-1:0] address_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      request_q    <= 1'b0;
      frame_done_q <= 1'b0;
      address_q    <= '0;
    end else begin
      request_q    <= s2_valid;
      frame_done_q <= s2_valid && s2_last;
      if (s2_valid) begin
        address_q <= s2_base + s2_row * s2_w + s2_col;
      end
    end
  end

  assign bus.request     = request_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.address_out = address_q;
  assign bus.layer_out   = layer_lat;

  // ---------------------------------------------------------------------------
  // FSM. A latch always re-decides the state; otherwise ARMED moves to DONE in
  // the cycle the last-pixel request is registered, so DONE and frame_done
  // become visible together.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (latch) begin
      state_d = arm_ok ? ARMED : IDLE;
    end else if ((state_q == ARMED) && s2_valid && s2_last) begin
      state_d = DONE;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// -----------------------------------------------------------------------------
// tb_sprite_fetch
// Drives beam sweeps over a reduced raster (columns 0..15 plus a window around
// the right visible edge at 640) and compares every strobe against a
// behavioural model working on integer screen/source coordinates.
// -----------------------------------------------------------------------------
module tb_sprite_fetch;

  localparam int ADDR_W  = 8;
  localparam int POS_W   = 10;
  localparam int LAYER_W = 2;
  localparam int NX      = 16;
  localparam int NY      = 20;
  localparam int WIN0    = 630;
  localparam int WIN1    = 645;
  localparam int VIS_W   = 640;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  sprite_fetch_if #(.ADDR_W(ADDR_W), .POS_W(POS_W), .LAYER_W(LAYER_W)) bus ();

  sprite_fetch #(.ADDR_W(ADDR_W), .POS_W(POS_W), .LAYER_W(LAYER_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: shadow copy plus integer geometry
  // ---------------------------------------------------------------------------
  int m_x, m_y, m_w, m_h, m_sx, m_sy, m_fh, m_fv, m_base, m_layer;
  bit m_armed, m_done;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_w = 0; m_h = 0; m_sx = 0; m_sy = 0;
    m_fh = 0; m_fv = 0; m_base = 0; m_layer = 0;
    m_armed = 0; m_done = 0;
  endtask

  task automatic model_pixel(input int x, input int y, input bit blank,
                             output bit req, output logic [ADDR_W-1:0] addr, output bit last);
    int dx, dy, ew, eh, col, row, fx, fy;
    if (x == 0 && y == 0) begin
      m_x = int'(bus.x_pos); m_y = int'(bus.y_pos);
      m_w = int'(bus.width); m_h = int'(bus.height);
      m_sx = int'(bus.scale_x); m_sy = int'(bus.scale_y);
      m_fh = int'(bus.flip_h); m_fv = int'(bus.flip_v);
      m_base = int'(bus.address_in); m_layer = int'(bus.layer_in);
      m_armed = bus.sprite_enable && m_w != 0 && m_h != 0;
      m_done = 0;
    end
    req = 0; last = 0; addr = '0;
    if (m_armed && !m_done && !blank) begin
      fx = 1 << m_sx;
      fy = 1 << m_sy;
      dx = x - m_x;
      dy = y - m_y;
      ew = m_w * fx;
      eh = m_h * fy;
      if (dx >= 0 && dx < ew && dy >= 0 && dy < eh) begin
        col = dx / fx;
        row = dy / fy;
        if (m_fh != 0) col = m_w - 1 - col;
        if (m_fv != 0) row = m_h - 1 - row;
        addr = ADDR_W'((m_base + row * m_w + col) % (1 << ADDR_W));
        req = 1;
        last = (dx == ew - 1) && (dy == eh - 1);
        if (last) m_done = 1;
      end
    end
  endtask

  function automatic logic [1:0] exp_state();
    if (!m_armed) return 2'd0;
    return m_done ? 2'd2 : 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  int f_req, f_done;
  logic [ADDR_W-1:0] f_first, f_last;

  // One strobe period: strobe cycle, then three cycles; result due in the last.
  task automatic pixel(input int x, input int y, input bit rst_mid);
    bit blank, req, last, early;
    logic [ADDR_W-1:0] a, e;
    blank = (x >= VIS_W);
    bus.clk25en    = 1'b1;
    bus.curr_x_pos = POS_W'(x);
    bus.curr_y_pos = POS_W'(y);
    bus.blank      = blank;
    model_pixel(x, y, blank, req, a, last);
    @(posedge clk); #1;
    bus.clk25en = 1'b0;
    early = bus.request;
    if (rst_mid) begin
      resetn = 1'b0;
      model_reset();
      req = 0;
      last = 0;
    end
    @(posedge clk); #1;
    early |= bus.request;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("early_req", 32'(early), 32'd0);
    check("req", 32'(bus.request), 32'(req));
    check("frame_done", 32'(bus.frame_done), 32'(last));
    check("layer", 32'(bus.layer_out), 32'(m_layer));
    check("state", 32'(state_dbg), 32'(exp_state()));
    if (req) exp_q.push_back(a);
    if (bus.request) begin
      if (f_req == 0) f_first = bus.address_out;
      f_last = bus.address_out;
      f_req++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("addr", 32'(bus.address_out), 32'(e));
      end
    end
    exp_q.delete();
    if (bus.frame_done) f_done++;
    if (rst_mid) begin
      check("rst_addr", 32'(bus.address_out), 32'd0);
      check("rst_layer", 32'(bus.layer_out), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int mid_row, input int new_x, input bit new_en,
                           input int rst_x, input int rst_y);
    f_req = 0; f_done = 0; f_first = '0; f_last = '0;
    for (int y = 0; y < NY; y++) begin
      if (y == mid_row) begin
        bus.x_pos = POS_W'(new_x);
        bus.sprite_enable = new_en;
      end
      for (int x = 0; x < NX; x++) pixel(x, y, (x == rst_x) && (y == rst_y));
      for (int x = WIN0; x <= WIN1; x++) pixel(x, y, 1'b0);
    end
  endtask

  task automatic set_sprite(input int x, input int y, input int w, input int h,
                            input int sx, input int sy, input bit fh, input bit fv,
                            input int base, input int layer, input bit en);
    bus.x_pos = POS_W'(x); bus.y_pos = POS_W'(y);
    bus.width = ADDR_W'(w); bus.height = ADDR_W'(h);
    bus.scale_x = 2'(sx); bus.scale_y = 2'(sy);
    bus.flip_h = fh; bus.flip_v = fv;
    bus.address_in = ADDR_W'(base); bus.layer_in = LAYER_W'(layer);
    bus.sprite_enable = en;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    bus.clk25en = 1'b0; bus.curr_x_pos = '0; bus.curr_y_pos = '0; bus.blank = 1'b0;
    set_sprite(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_req", 32'(bus.request), 32'd0);
    check("reset_addr", 32'(bus.address_out), 32'd0);
    check("reset_done", 32'(bus.frame_done), 32'd0);
    check("reset_layer", 32'(bus.layer_out), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Plain 4x4 sprite
    set_sprite(5, 2, 4, 4, 0, 0, 0, 0, 'h10, 1, 1);
    run_frame(-1, 0, 0, -1, -1);
    check("t1_count", 32'(f_req), 32'd16);
    check("t1_first", 32'(f_first), 32'h10);
    check("t1_last", 32'(f_last), 32'h1F);
    check("t1_done", 32'(f_done), 32'd1);
    check("t1_state", 32'(state_dbg), 32'd2);

    // Scaled 2x horizontally, 4x vertically
    set_sprite(5, 2, 4, 4, 1, 2, 0, 0, 'h10, 2, 1);
    run_frame(-1, 0, 0, -1, -1);
    check("t2_count", 32'(f_req), 32'd128);
    check("t2_done", 32'(f_done), 32'd1);

    // Both mirrors
    set_sprite(5, 2, 4, 4, 0, 0, 1, 1, 0, 3, 1);
    run_frame(-1, 0, 0, -1, -1);
    check("t3_first", 32'(f_first), 32'd15);
    check("t3_last", 32'(f_last), 32'd0);
    check("t3_done", 32'(f_done), 32'd1);

    // Address wrap
    set_sprite(5, 2, 4, 1, 0, 0, 0, 0, 'hFE, 0, 1);
    run_frame(-1, 0, 0, -1, -1);
    check("t4_count", 32'(f_req), 32'd4);
    check("t4_first", 32'(f_first), 32'hFE);
    check("t4_last", 32'(f_last), 32'h01);

    // Zero width
    set_sprite(5, 2, 0, 4, 0, 0, 0, 0, 'h10, 1, 1);
    run_frame(-1, 0, 0, -1, -1);
    check("t4b_count", 32'(f_req), 32'd0);
    check("t4b_state", 32'(state_dbg), 32'd0);

    // Mid-frame change of x_pos and enable
    set_sprite(5, 2, 4, 4, 0, 0, 0, 0, 'h10, 1, 1);
    run_frame(3, 9, 1'b0, -1, -1);
    check("t5_count", 32'(f_req), 32'd16);
    check("t5_first", 32'(f_first), 32'h10);
    check("t5_done", 32'(f_done), 32'd1);
    run_frame(-1, 0, 0, -1, -1);
    check("t5_disabled_count", 32'(f_req), 32'd0);
    check("t5_disabled_state", 32'(state_dbg), 32'd0);
    bus.sprite_enable = 1'b1;
    run_frame(-1, 0, 0, -1, -1);
    check("t5_moved_count", 32'(f_req), 32'd16);
    check("t5_moved_done", 32'(f_done), 32'd1);

    // Right-edge clipping
    set_sprite(638, 0, 8, 2, 0, 0, 0, 0, 'h20, 1, 1);
    run_frame(-1, 0, 0, -1, -1);
    check("t5b_count", 32'(f_req), 32'd4);
    check("t5b_done", 32'(f_done), 32'd0);
    check("t5b_state", 32'(state_dbg), 32'd1);

    // Reset between a strobe and its request
    set_sprite(5, 2, 4, 4, 0, 0, 0, 0, 'h10, 1, 1);
    run_frame(-1, 0, 0, 6, 2);
    check("t6_count", 32'(f_req), 32'd1);
    check("t6_state", 32'(state_dbg), 32'd0);
    run_frame(-1, 0, 0, -1, -1);
    check("t6_resume_count", 32'(f_req), 32'd16);
    check("t6_resume_done", 32'(f_done), 32'd1);

    // Randomized sprites
    for (int i = 0; i < 6; i++) begin
      set_sprite($urandom_range(0, 8), $urandom_range(0, 4), $urandom_range(1, 6),
                 $urandom_range(1, 4), $urandom_range(0, 1), $urandom_range(0, 1),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 255), $urandom_range(0, 3),
                 $urandom_range(0, 7) != 0);
      run_frame(-1, 0, 0, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
